div_ctrl: RTL
=============

// Module: div_ctrl
// PURPOSE
//  Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, which the single-cycle ALU does not execute.
//  The ALU issues a start pulse with operands; this block stalls the pipeline and runs a 1-bit/cycle
//  restoring divider. It then returns the result with its write-back tag. A ctrl-stage flush cancels it.
// PARAMETERS
//  DATA_W  32  operand/result width; counter width = $clog2(DATA_W)+1
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       asynchronous reset, active-high
//  start_i          in   1       div-class inst in ALU stage (opcode 0110011, funct7 0000001, funct3[2]=1)
//  funct3_i         in   3       100 DIV, 101 DIVU, 110 REM, 111 REMU
//  dividend_i       in   DATA_W  rs1 value
//  divisor_i        in   DATA_W  rs2 value
//  wr_reg_addr_i    in   5       rd tag
//  flush_i          in   1       jump_flag from ctrl; cancels any in-flight op
//  stall_o          out  1       hold pipeline front (combinational)
//  done_o           out  1       1-cycle pulse, result valid
//  result_o         out  DATA_W  quotient or remainder
//  wr_reg_en_o      out  1       = done_o
//  wr_reg_addr_o    out  5       captured rd tag
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-high.
//    rst -> state IDLE; count, result_o, wr_reg_addr_o, and internal operands all 0; done_o=0.
//  - States: IDLE, CALC, END.
//  - IDLE & start_i & ~flush_i: capture funct3, rd, and operand magnitudes.
//    Signed ops (funct3[0]=0): |x| = ~x+1 when the sign bit is set. Unsigned ops use raw values.
//    Record neg_q = sign(a)^sign(b) for signed ops; neg_r = sign(a) for signed ops.
//    - divisor==0: next state END. Quotient = all-ones; remainder = dividend_i (raw).
//    - DIV/REM with a=0x80000000, b=0xFFFFFFFF: next state END. Quotient = 0x80000000; remainder = 0.
//    - Otherwise: next state CALC, count=0, rem_acc=0.
//  - CALC: each cycle shift {rem_acc,quot} left by 1 and trial-subtract the divisor magnitude.
//    On no borrow, keep the difference and set quotient bit 0 to 1.
//    After DATA_W iterations (count==DATA_W-1), go to END.
//  - END: done_o=1 and wr_reg_en_o=1 for exactly 1 cycle, then IDLE.
//    result_o = funct3[1] ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot).
//    Special-case values bypass the sign fix.
//  - result_o and wr_reg_addr_o are registered and hold their value until the next END.
//  - stall_o = (IDLE & start_i & ~flush_i) | CALC. It is 0 in END so the pipeline advances with write-back.
//  - Latency: normal op has the start edge at cycle 0 and done_o at cycle DATA_W+1 (33).
//    Special cases raise done_o at cycle 1.
//  - start_i is ignored outside IDLE. A back-to-back start is accepted in the IDLE cycle after END.
//  - flush_i in CALC or END: next state IDLE, no done_o, result_o unchanged. flush_i in IDLE blocks capture.
//  - flush_i and start_i in the same IDLE cycle: flush wins.
//  - Reset mid-CALC: immediate IDLE, stall_o=0, no done_o after release.
// TESTING
//  1. DIVU 100/7 -> stall_o high for 33 cycles; done_o at cycle 33; result 14; rd tag echoed.
//     REMU 100/7 -> 2.
//  2. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIV 7/-2 -> 0xFFFFFFFD. REM 7/-2 -> 1.
//  3. DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done_o at cycle 1.
//     DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB.
//  4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; done_o at cycle 1.
//  5. flush_i at CALC count=10 -> IDLE next cycle, no done_o, stall_o drops.
//     A new DIVU 9/3 issued after the flush -> 3 at cycle 33.
//  6. rst pulsed mid-CALC -> all outputs 0 immediately; start_i held during rst is ignored.
//     Random signed/unsigned sweep (10k ops) checked against a reference model.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline front while a 1-bit-per-cycle restoring divider runs.
// Then it emits a one-cycle write-back pulse with the result and the rd tag.
module div_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [4:0]        wr_reg_addr_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              wr_reg_en_o,
    output logic [4:0]        wr_reg_addr_o
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_fn;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_addr;

    logic              w_accept;
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_no_borrow;
    logic [DATA_W-1:0] w_final;

    // A non-divide funct3 encoding is never claimed, and nothing is claimed while reset is held.
    assign w_accept  = (r_state == S_IDLE) & start_i & ~flush_i & ~rst & funct3_i[2];
    assign w_signed  = ~funct3_i[0];
    assign w_a_neg   = w_signed & dividend_i[DATA_W-1];
    assign w_b_neg   = w_signed & divisor_i[DATA_W-1];
    assign w_a_mag   = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_mag   = w_b_neg ? -divisor_i  : divisor_i;
    assign w_div0    = (divisor_i == '0);
    assign w_ovf     = w_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
    assign w_special = w_div0 | w_ovf;

    assign w_shift     = {r_rem, r_quot[DATA_W-1]};
    assign w_diff      = w_shift - {1'b0, r_dvs};
    assign w_no_borrow = ~w_diff[DATA_W];

    // Special cases clear both sign flags at capture, so they pass through unmodified here.
    assign w_final = r_fn[1] ? (r_neg_r ? -r_rem : r_rem)
                             : (r_neg_q ? -r_quot : r_quot);

    assign stall_o       = w_accept | (r_state == S_CALC);
    assign done_o        = r_done;
    assign wr_reg_en_o   = r_done;
    assign result_o      = r_result;
    assign wr_reg_addr_o = r_addr;

    // Sequencer state: IDLE -> CALC (or straight to END for special cases) -> END -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= w_special ? S_END : S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (r_count == LAST_CNT) begin
                        r_state <= S_END;
                    end
                end
                S_END:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand capture and one restoring-division step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_fn    <= '0;
            r_rd    <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_fn    <= funct3_i[1:0];
            r_rd    <= wr_reg_addr_i;
            r_count <= '0;
            r_dvs   <= w_b_mag;
            if (w_div0) begin
                r_quot  <= '1;
                r_rem   <= dividend_i;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else if (w_ovf) begin
                r_quot  <= MIN_NEG;
                r_rem   <= '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_quot  <= w_a_mag;
                r_rem   <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
        end else if (r_state == S_CALC) begin
            r_count <= r_count + CNT_W'(1);
            if (w_no_borrow) begin
                r_rem  <= w_diff[DATA_W-1:0];
                r_quot <= {r_quot[DATA_W-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[DATA_W-1:0];
                r_quot <= {r_quot[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Write-back register: loaded on an unflushed END, then held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_addr   <= '0;
        end else if ((r_state == S_END) && !flush_i) begin
            r_done   <= 1'b1;
            r_result <= w_final;
            r_addr   <= r_rd;
        end else begin
            r_done   <= 1'b0;
        end
    end

endmodule
